// File: rtl/vm_button_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vm_button_pkg
// Description : Shared types and constant helpers for the front-panel button
//               event arbiter (FSM state encoding, ms->cycle conversion,
//               event-id width).
// Revision    : 1.0 - initial release
// ============================================================================
package vm_button_pkg;

    // Offer FSM: either looking for a pending request or holding one offer.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arb_state_t;

    localparam int MIN_ID_W = 1;

    // Converts a millisecond interval to clock cycles at the given frequency.
    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

    // Width of a button index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : MIN_ID_W;
    endfunction

endpackage : vm_button_pkg
`default_nettype wire

// File: rtl/button_event_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : button_event_arbiter_if
// Description : Valid/ready event stream carrying one button event at a time
//               from the arbiter (master) to the vending controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface button_event_arbiter_if #(
    parameter int ID_W = 2
);
    logic            valid;
    logic            ready;
    logic [ID_W-1:0] id;
    logic            rpt;

    modport master (output valid, output id, output rpt, input ready);
    modport slave  (input valid, input id, input rpt, output ready);
endinterface : button_event_arbiter_if
`default_nettype wire

// File: rtl/button_repeat_timer.sv
`default_nettype none
// ============================================================================
// Module      : button_repeat_timer
// Description : Per-button hold timer. Emits a one-cycle repeat strobe after
//               DELAY_CYCLES of continuous hold, then every RATE_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module button_repeat_timer #(
    parameter int DELAY_CYCLES = 5,
    parameter int RATE_CYCLES  = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_held,
    input  wire logic i_press,
    output logic      o_rpt
);
    localparam int CNT_W = $clog2(DELAY_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_rpt;

    // Count hold cycles; restart on a fresh press or release, reload after each strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_rpt <= 1'b0;
        end else begin
            r_rpt <= 1'b0;
            if (!i_held || i_press) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DELAY_CYCLES - 1)) begin
                r_rpt <= 1'b1;
                r_cnt <= CNT_W'(DELAY_CYCLES - RATE_CYCLES);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_rpt = r_rpt;

endmodule : button_repeat_timer
`default_nettype wire

// File: rtl/button_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : button_event_arbiter
// Description : Turns active-low debounced button levels into a serialized,
//               round-robin arbitrated valid/ready event stream with optional
//               per-button auto-repeat and request-overrun reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module button_event_arbiter
    import vm_button_pkg::*;
#(
    parameter int                    NUM_BUTTONS     = 4,
    parameter int                    CLOCK_FREQUENCY = 50000000,
    parameter int                    REPEAT_DELAY_MS = 500,
    parameter int                    REPEAT_RATE_MS  = 100,
    parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK    = '0
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic [NUM_BUTTONS-1:0] i_buttons_n,
    input  wire logic                   i_enable,
    button_event_arbiter_if.master      evt,
    output logic      [NUM_BUTTONS-1:0] o_pending,
    output logic                        o_overrun
);
    localparam int ID_W         = id_width(NUM_BUTTONS);
    localparam int DELAY_CYCLES = ms_to_cycles(CLOCK_FREQUENCY, REPEAT_DELAY_MS);
    localparam int RATE_CYCLES  = ms_to_cycles(CLOCK_FREQUENCY, REPEAT_RATE_MS);

    logic [NUM_BUTTONS-1:0] r_prev;
    logic [NUM_BUTTONS-1:0] r_press;
    logic [NUM_BUTTONS-1:0] r_pending;
    logic [NUM_BUTTONS-1:0] r_rep_flag;
    logic                   r_overrun;
    arb_state_t             r_state;
    logic                   r_valid;
    logic [ID_W-1:0]        r_id;
    logic                   r_repeat;
    logic [ID_W-1:0]        r_last;

    logic [NUM_BUTTONS-1:0] w_press_now;
    logic [NUM_BUTTONS-1:0] w_rpt;
    logic [NUM_BUTTONS-1:0] w_req;
    logic [NUM_BUTTONS-1:0] w_clear;
    logic                   w_accept;
    logic [ID_W-1:0]        w_pick;

    // First pending bit strictly above the last grant, else the lowest pending bit.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_BUTTONS-1:0] pend,
                                                 input logic [ID_W-1:0]        last);
        logic [NUM_BUTTONS-1:0] above;
        logic [ID_W-1:0]        sel;
        logic                   found;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            above[i] = (i > int'(last));
        end
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (!found && pend[i] && above[i]) begin
                sel   = ID_W'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (!found && pend[i]) begin
                sel   = ID_W'(i);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign w_press_now = r_prev & ~i_buttons_n;
    assign w_req       = {NUM_BUTTONS{i_enable}} & (r_press | w_rpt);
    assign w_accept    = r_valid & evt.ready;
    assign w_clear     = w_accept ? ({{(NUM_BUTTONS-1){1'b0}}, 1'b1} << r_id) : '0;
    assign w_pick      = rr_pick(r_pending, r_last);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
            if (REPEAT_MASK[gi]) begin : g_rpt_on
                button_repeat_timer #(
                    .DELAY_CYCLES (DELAY_CYCLES),
                    .RATE_CYCLES  (RATE_CYCLES)
                ) u_timer (
                    .clk     (clk),
                    .rst     (rst),
                    .i_held  (~i_buttons_n[gi]),
                    .i_press (w_press_now[gi]),
                    .o_rpt   (w_rpt[gi])
                );
            end else begin : g_rpt_off
                assign w_rpt[gi] = 1'b0;
            end
        end
    endgenerate

    // Edge detection: previous level follows the input every cycle, independent of enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev  <= '1;
            r_press <= '0;
        end else begin
            r_prev  <= i_buttons_n;
            r_press <= w_press_now;
        end
    end

    // Pending flags: a new request beats the acceptance clear; a request on an already-pending button is an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending  <= '0;
            r_rep_flag <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_pending  <= (r_pending & ~w_clear) | w_req;
            r_rep_flag <= (r_rep_flag & ~w_req) | (w_req & ~r_press);
            r_overrun  <= |(w_req & r_pending & ~w_clear);
        end
    end

    // Offer FSM: latch a round-robin pick, hold it until the consumer accepts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_valid  <= 1'b0;
            r_id     <= '0;
            r_repeat <= 1'b0;
            r_last   <= ID_W'(NUM_BUTTONS - 1);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|r_pending) begin
                        r_id     <= w_pick;
                        r_repeat <= r_rep_flag[w_pick];
                        r_valid  <= 1'b1;
                        r_state  <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (evt.ready) begin
                        r_valid <= 1'b0;
                        r_last  <= r_id;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign evt.valid = r_valid;
    assign evt.id    = r_id;
    assign evt.rpt   = r_repeat;
    assign o_pending = r_pending;
    assign o_overrun = r_overrun;

endmodule : button_event_arbiter
`default_nettype wire

// File: tb/tb_button_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_event_arbiter
// Description : Self-checking bench for button_event_arbiter: directed
//               front-panel scenarios plus randomized button/enable/ready
//               traffic compared every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event_arbiter;
    localparam int         N     = 4;
    localparam int         CF    = 1000;
    localparam int         DMS   = 5;
    localparam int         RMS   = 2;
    localparam logic [3:0] MASK  = 4'b0100;
    localparam int         D     = CF / 1000 * DMS;
    localparam int         R     = CF / 1000 * RMS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] buttons_n = 4'b1111;
    logic       enable = 1'b1;
    logic [3:0] pending;
    logic       overrun;

    button_event_arbiter_if #(.ID_W(2)) evt_if ();

    button_event_arbiter #(
        .NUM_BUTTONS     (N),
        .CLOCK_FREQUENCY (CF),
        .REPEAT_DELAY_MS (DMS),
        .REPEAT_RATE_MS  (RMS),
        .REPEAT_MASK     (MASK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_buttons_n (buttons_n),
        .i_enable    (enable),
        .evt         (evt_if.master),
        .o_pending   (pending),
        .o_overrun   (overrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each button's hold length (in samples) decides press/repeat directly:
    // press on the first low sample, repeats at hold lengths D+1, D+1+R, ...
    int       m_hold [N];
    bit [3:0] m_ev_stage, m_rep_stage;
    bit [3:0] m_pend, m_repf;
    bit       m_valid, m_rpt, m_ovr;
    int       m_id, m_last;

    int cyc = 0;
    int ev_id[$];
    int ev_rep[$];
    int ev_t[$];
    int ovr_cnt = 0;

    always @(posedge clk) begin
        if (!rst && evt_if.valid && evt_if.ready) begin
            ev_id.push_back(int'(evt_if.id));
            ev_rep.push_back(int'(evt_if.rpt));
            ev_t.push_back(cyc);
        end
        cyc++;
        if (rst) begin
            for (int i = 0; i < N; i++) m_hold[i] = 0;
            m_ev_stage = '0; m_rep_stage = '0;
            m_pend = '0; m_repf = '0;
            m_valid = 0; m_rpt = 0; m_ovr = 0;
            m_id = 0; m_last = N - 1;
        end else begin
            bit       acc;
            bit [3:0] req, old_pend;
            int       acc_id;
            bit       found;
            acc      = m_valid && evt_if.ready;
            acc_id   = m_id;
            old_pend = m_pend;
            req      = enable ? m_ev_stage : 4'b0000;
            m_ovr    = 0;
            for (int i = 0; i < N; i++)
                if (req[i] && old_pend[i] && !(acc && acc_id == i)) m_ovr = 1;
            if (m_valid) begin
                if (acc) begin
                    m_valid = 0;
                    m_last  = m_id;
                end
            end else begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    int idx;
                    idx = (m_last + k) % N;
                    if (!found && old_pend[idx]) begin
                        found   = 1;
                        m_valid = 1;
                        m_id    = idx;
                        m_rpt   = m_repf[idx];
                    end
                end
            end
            if (acc) m_pend[acc_id] = 0;
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    m_pend[i] = 1;
                    m_repf[i] = m_rep_stage[i];
                end
            end
            for (int i = 0; i < N; i++) begin
                bit pr, rp;
                if (!buttons_n[i]) m_hold[i]++; else m_hold[i] = 0;
                pr = (m_hold[i] == 1);
                rp = MASK[i] && (m_hold[i] > D) && (((m_hold[i] - 1 - D) % R) == 0);
                m_ev_stage[i]  = pr | rp;
                m_rep_stage[i] = rp & ~pr;
            end
        end
    end

    // Compare DUT outputs against the model on the falling edge.
    always @(negedge clk) begin
        check_val("valid", evt_if.valid, m_valid);
        check_val("pending", pending, m_pend);
        check_val("overrun", overrun, m_ovr);
        if (m_valid) begin
            check_val("id", evt_if.id, m_id);
            check_val("repeat", evt_if.rpt, m_rpt);
        end
        if (overrun === 1'b1) ovr_cnt++;
    end

    // ---------------- helpers ----------------
    function automatic int ev_id_at(int k);
        return (k < ev_id.size()) ? ev_id[k] : -1;
    endfunction
    function automatic int ev_rep_at(int k);
        return (k < ev_rep.size()) ? ev_rep[k] : -1;
    endfunction
    function automatic int ev_t_at(int k);
        return (k < ev_t.size()) ? ev_t[k] : -100000;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        ev_id.delete();
        ev_rep.delete();
        ev_t.delete();
        ovr_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; buttons_n = 4'b1111; enable = 1'b1; evt_if.ready = 1'b1;
        idle(2);
        rst = 1'b0;
        clear_log();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int tdrv;
        evt_if.ready = 1'b1;

        // Reset behaviour
        idle(2);
        check_val("rst_valid", evt_if.valid, 0);
        check_val("rst_id", evt_if.id, 0);
        check_val("rst_repeat", evt_if.rpt, 0);
        check_val("rst_pending", pending, 0);
        check_val("rst_overrun", overrun, 0);
        rst = 1'b0;
        clear_log();
        idle(20);
        check_val("rst_quiet_events", ev_id.size(), 0);

        // Simultaneous presses on buttons 0 and 2
        do_reset();
        tdrv = cyc;
        buttons_n = 4'b1010;
        idle(4);
        buttons_n = 4'b1111;
        idle(8);
        check_val("simul_count", ev_id.size(), 2);
        check_val("simul_id0", ev_id_at(0), 0);
        check_val("simul_id1", ev_id_at(1), 2);
        check_val("simul_rep0", ev_rep_at(0), 0);
        check_val("simul_rep1", ev_rep_at(1), 0);
        check_val("simul_latency", ev_t_at(0) - tdrv, 3);
        check_val("simul_spacing", ev_t_at(1) - ev_t_at(0), 2);
        check_val("simul_pending", pending, 0);

        // Round-robin fairness
        do_reset();
        evt_if.ready = 1'b0;
        buttons_n = 4'b0101;
        idle(3);
        buttons_n = 4'b1111;
        idle(3);
        evt_if.ready = 1'b1;
        idle(1);
        evt_if.ready = 1'b0;
        buttons_n = 4'b1101;
        idle(3);
        buttons_n = 4'b1111;
        idle(3);
        evt_if.ready = 1'b1;
        idle(8);
        check_val("rr_count", ev_id.size(), 3);
        check_val("rr_id0", ev_id_at(0), 1);
        check_val("rr_id1", ev_id_at(1), 3);
        check_val("rr_id2", ev_id_at(2), 1);

        // Overrun
        do_reset();
        evt_if.ready = 1'b0;
        buttons_n = 4'b1110;
        idle(2);
        buttons_n = 4'b1111;
        idle(2);
        buttons_n = 4'b1110;
        idle(2);
        buttons_n = 4'b1111;
        idle(5);
        evt_if.ready = 1'b1;
        idle(6);
        check_val("ovr_pulses", ovr_cnt, 1);
        check_val("ovr_events", ev_id.size(), 1);
        check_val("ovr_id", ev_id_at(0), 0);

        // Auto-repeat on button 2, none on button 1
        do_reset();
        buttons_n = 4'b1011;
        idle(12);
        buttons_n = 4'b1111;
        idle(10);
        check_val("rpt_count", ev_id.size(), 5);
        for (int k = 0; k < 5; k++) begin
            check_val($sformatf("rpt_id%0d", k), ev_id_at(k), 2);
            check_val($sformatf("rpt_flag%0d", k), ev_rep_at(k), (k == 0) ? 0 : 1);
        end
        check_val("rpt_t1", ev_t_at(1) - ev_t_at(0), 5);
        check_val("rpt_t2", ev_t_at(2) - ev_t_at(0), 7);
        check_val("rpt_t3", ev_t_at(3) - ev_t_at(0), 9);
        check_val("rpt_t4", ev_t_at(4) - ev_t_at(0), 11);
        clear_log();
        buttons_n = 4'b1101;
        idle(12);
        buttons_n = 4'b1111;
        idle(10);
        check_val("norpt_count", ev_id.size(), 1);
        check_val("norpt_rep", ev_rep_at(0), 0);

        // Enable gating
        do_reset();
        enable = 1'b0;
        buttons_n = 4'b0111;
        idle(3);
        enable = 1'b1;
        idle(5);
        buttons_n = 4'b1111;
        idle(5);
        check_val("en_blocked", ev_id.size(), 0);
        buttons_n = 4'b0111;
        idle(3);
        buttons_n = 4'b1111;
        idle(8);
        check_val("en_count", ev_id.size(), 1);
        check_val("en_id", ev_id_at(0), 3);

        // Randomized traffic against the model
        do_reset();
        repeat (1500) begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 9) == 0) buttons_n[i] = ~buttons_n[i];
            enable       = ($urandom_range(0, 7) != 0);
            evt_if.ready = ($urandom_range(0, 2) != 0);
            rst          = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_button_event_arbiter
`default_nettype wire
